// File: rtl/sum_of_squares_seq_if.sv
// Operand/result handshake bundle between the radicand producer, this unit and
// the square-root stage downstream.
interface sum_of_squares_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   x_in;
    logic [WIDTH-1:0]   y_in;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH:0]   sum_out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output x_in, y_in, in_valid, out_ready,
        input  in_ready, sum_out, out_valid, busy
    );

    modport slave (
        input  x_in, y_in, in_valid, out_ready,
        output in_ready, sum_out, out_valid, busy
    );
endinterface

// File: rtl/sum_of_squares_seq.sv
// Iterative shift-add x^2 + y^2: one multiplier bit of each operand per cycle,
// one transaction in flight, valid/ready on both sides.
module sum_of_squares_seq #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sum_of_squares_seq_if.slave   bus
);
    localparam int SW    = 2 * WIDTH + 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [SW-1:0]      term_x_s, term_y_s, acc_next_s;

    // Both partial products for the current bit are folded in the same cycle.
    always_comb begin
        term_x_s   = x_q[cnt_q] ? (SW'(x_q) << cnt_q) : {SW{1'b0}};
        term_y_s   = y_q[cnt_q] ? (SW'(y_q) << cnt_q) : {SW{1'b0}};
        acc_next_s = acc_q + term_x_s + term_y_s;
    end

    // Next-state and datapath control for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.x_in;
                    y_d     = bus.y_in;
                    acc_d   = {SW{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = acc_next_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d       = acc_next_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                // No bypass to IDLE accept: in_ready only rises the cycle after.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= {WIDTH{1'b0}};
            y_q         <= {WIDTH{1'b0}};
            acc_q       <= {SW{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            sum_q       <= {SW{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.sum_out   = sum_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sum_of_squares_seq.sv
// Scoreboard bench: accepted pairs push x*x+y*y with the cycle the result is due;
// a negedge monitor checks result, latency, hold-under-backpressure and handshakes.
module tb_sum_of_squares_seq;
    localparam int WIDTH = 8;

    typedef struct {
        int sum;
        int due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   n_results;
    int   n_accepts;
    bit   bp_en;
    exp_t sb_q[$];
    int   acc_cycles[$];

    sum_of_squares_seq_if #(.WIDTH(WIDTH)) bus ();

    sum_of_squares_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: observes accepts and results half a cycle away from the active edge.
    bit prev_valid;
    bit ready_due;
    int held_sum;
    initial begin
        prev_valid = 1'b0;
        ready_due  = 1'b0;
        held_sum   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                ready_due  = 1'b0;
            end else begin
                check("ready_vs_busy", int'(bus.in_ready), int'(!bus.busy));
                if (ready_due) begin
                    check("ready_after_consume", int'(bus.in_ready), 1);
                    ready_due = 1'b0;
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_t e;
                    e.sum = int'(bus.x_in) * int'(bus.x_in) + int'(bus.y_in) * int'(bus.y_in);
                    e.due = cyc + 1 + WIDTH;
                    sb_q.push_back(e);
                    acc_cycles.push_back(cyc + 1);
                    n_accepts++;
                end
                if (bus.out_valid) begin
                    if (!prev_valid) begin
                        if (sb_q.size() == 0) begin
                            check("spurious_result", int'(bus.sum_out), -1);
                        end else begin
                            check("sum", int'(bus.sum_out), sb_q[0].sum);
                            check("latency", cyc, sb_q[0].due);
                        end
                    end else begin
                        check("sum_hold", int'(bus.sum_out), held_sum);
                    end
                    held_sum = int'(bus.sum_out);
                    if (bus.out_ready) begin
                        if (sb_q.size() != 0) void'(sb_q.pop_front());
                        n_results++;
                        ready_due = 1'b1;
                    end
                end
                prev_valid = bus.out_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int x, input int y, input bit hold);
        bit done;
        done = 1'b0;
        bus.x_in     = WIDTH'(x);
        bus.y_in     = WIDTH'(y);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.in_ready) done = 1'b1;
            tick();
        end
        if (!done) check("accept_timeout", 0, 1);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (sb_q.size() == 0 && bus.in_ready && !bus.out_valid) done = 1'b1;
            else tick();
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int r0, a0;
        n_checks = 0; n_fail = 0; n_results = 0; n_accepts = 0; bp_en = 1'b0;
        rst_n = 1'b0;
        bus.x_in = '0; bus.y_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #12;
        check("rst_sum", int'(bus.sum_out), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        #10 rst_n = 1'b1;
        tick();

        // Basic and extremes.
        send(3, 4, 1'b0);
        check("busy_in_calc", int'(bus.busy), 1);
        drain();
        send(255, 255, 1'b0); drain();
        send(0, 0, 1'b0);     drain();
        send(255, 0, 1'b0);   drain();

        // Backpressure: held result, single consumption.
        r0 = n_results;
        bus.out_ready = 1'b0;
        send(12, 5, 1'b0);
        for (int i = 0; i < 50 && !bus.out_valid; i++) tick();
        repeat (6) tick();
        check("bp_valid_held", int'(bus.out_valid), 1);
        check("bp_sum_169", int'(bus.sum_out), 169);
        bus.out_ready = 1'b1;
        drain();
        repeat (5) tick();
        check("bp_single_result", n_results - r0, 1);

        // Inputs ignored during CALC.
        r0 = n_results; a0 = n_accepts;
        send(6, 8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.x_in = WIDTH'($urandom);
            bus.y_in = WIDTH'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        drain();
        repeat (4) tick();
        check("ignored_one_accept", n_accepts - a0, 1);
        check("ignored_one_result", n_results - r0, 1);
        check("ignored_last_sum", int'(bus.sum_out), 100);

        // Back-to-back stream with in_valid held.
        acc_cycles.delete();
        send(1, 1, 1'b1);
        send(7, 24, 1'b1);
        send(100, 200, 1'b0);
        drain();
        check("stream_accepts", acc_cycles.size(), 3);
        if (acc_cycles.size() == 3) begin
            check("stream_gap1", acc_cycles[1] - acc_cycles[0], WIDTH + 2);
            check("stream_gap2", acc_cycles[2] - acc_cycles[1], WIDTH + 2);
        end
        check("stream_last_sum", int'(bus.sum_out), 50000);

        // Reset mid-operation.
        send(9, 9, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_sum", int'(bus.sum_out), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("midrst_no_pulse", int'(bus.out_valid), 0);
        send(2, 3, 1'b0); drain();
        check("post_rst_sum", int'(bus.sum_out), 13);

        // Randomized pairs with random backpressure.
        bp_en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();
        bp_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("sb_empty", sb_q.size(), 0);
        check("accepts_eq_results", n_results, n_accepts - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
